sound_scheduler: RTL and testbench
==================================

Name: sound_scheduler

Overview:
Shares the single buzzer output between three note-divider sources: background music, a one-shot hit sound effect, and game-over music. A priority state machine selects the active source and inserts a silent gap before game-over. It pulses a restart to the game-over tune player so that tune starts at its first note, and converts the selected divider into the square wave that drives the buzzer pin. It sits between the per-tune music players and the top-level audio pin.

Parameters:
DIV_W, 22, width of every note divider
SFX_LEN, 12500000, sound-effect duration in clk cycles (0.25 s at 50 MHz); must be >= 2
GAP_LEN, 5000000, silence length in clk cycles before game-over music; must be >= 2
CNT_W, 24, width of the sfx/gap timer; must hold max(SFX_LEN, GAP_LEN)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
bgm_note_div  in  DIV_W  background-music half-period divider; 0 = rest
sfx_note_div  in  DIV_W  sound-effect divider; 0 = rest
go_note_div  in  DIV_W  game-over-music divider; 0 = rest
sfx_req  in  1  level; a rising edge requests the sound effect
game_over  in  1  level; sticky request for game-over music
mute  in  1  forces silence without affecting sequencing
note_div  out  DIV_W  registered selected divider
src  out  2  current source: 0 BGM, 1 SFX, 2 GAP, 3 OVER
sfx_busy  out  1  high while in SFX
go_start  out  1  one-cycle pulse; drive to the game-over player's rst
buzz  out  1  square-wave buzzer drive

Behaviour:
- Reset values:
  - state BGM; src 0; note_div 0; sfx_busy 0; go_start 0; buzz 0.
  - Timer 0; tone counter 0; sfx_req_d 0.
- Edge detect: sfx_rise = sfx_req & ~sfx_req_d; sfx_req_d is registered every cycle.
- State BGM:
  - game_over=1 -> GAP, timer loaded with GAP_LEN-1.
  - Else sfx_rise -> SFX, timer loaded with SFX_LEN-1.
  - Else stay in BGM.
- State SFX:
  - game_over=1 -> GAP, timer loaded with GAP_LEN-1. Takes priority over everything.
  - Else sfx_rise -> retrigger: timer reloaded with SFX_LEN-1, stay in SFX.
  - Else timer==0 -> BGM.
  - Else timer decrements.
- State GAP:
  - Selected divider is 0.
  - timer==0 -> OVER, with go_start=1 in that same transition cycle (registered, so it is visible the cycle OVER is entered).
  - Else timer decrements.
  - sfx_rise and game_over are ignored.
- State OVER:
  - Selects go_note_div.
  - Terminal; only rst exits.
  - sfx_rise is ignored.
- Simultaneous events: game_over and sfx_rise in the same BGM cycle -> game_over wins.
- Durations:
  - SFX lasts exactly SFX_LEN cycles (src=1) unless retriggered or pre-empted.
  - GAP lasts exactly GAP_LEN cycles.
- Output timing:
  - src and sfx_busy are registered state outputs.
  - note_div is registered: note_div(t+1) = mute ? 0 : divider selected by the state at t. This is one cycle of latency after src changes.
- Tone generation (sub-module):
  - note_div==0 -> buzz held at 0, counter held at 0.
  - Otherwise the counter runs 0..note_div-1; at note_div-1, buzz toggles and the counter returns to 0. Half-period = note_div cycles.
  - When note_div changes value, the counter clears to 0 and buzz keeps its level.
- rst mid-operation (any state, including OVER) returns all state and outputs to their reset values on the same edge. go_start does not pulse on reset.

Decomposition:
- Shared package:
  - Source/state encodings SRC_BGM=0, SRC_SFX=1, SRC_GAP=2, SRC_OVER=3.
  - DIV_W default.
  - Note divider constants used by all music players.
- One sub-module, tone_gen (clk, rst, note_div, buzz), holding the divider counter and toggle. It is reusable by the other audio blocks.

Test Plan (SFX_LEN=8, GAP_LEN=4, small dividers):
- Reset, bgm_note_div=5 -> note_div=5 one cycle after rst release; buzz toggles every 5 cycles.
- sfx_req rises in BGM with sfx_note_div=3 -> src=1 and sfx_busy=1 for exactly 8 cycles; note_div=3 lagging src by one cycle; then src=0 and note_div=5.
- Second sfx_req rise 5 cycles into SFX -> SFX continues 8 cycles from the retrigger (13 cycles total).
- game_over and sfx_req rise in the same cycle -> src=2 for 4 cycles with note_div=0; go_start high for exactly 1 cycle as src becomes 3; note_div then equals go_note_div; later sfx_req edges leave src=3.
- mute=1 during BGM -> note_div=0 and buzz=0 while src stays 0; mute=0 -> note_div returns to 5 and the tone counter restarts from 0.
- rst asserted in OVER mid-tone -> src=0, note_div=0, buzz=0 immediately, with no go_start pulse.

Source files
------------

// File: rtl/sound_scheduler_pkg.sv
// sound_scheduler_pkg: shared source encodings, divider width and note dividers for the audio blocks
package sound_scheduler_pkg;
  localparam int DIV_W_DEF = 22;
  typedef enum logic [1:0] {
    SRC_BGM  = 2'd0,
    SRC_SFX  = 2'd1,
    SRC_GAP  = 2'd2,
    SRC_OVER = 2'd3
  } src_e;
  // half-period dividers at 50 MHz
  localparam logic [DIV_W_DEF-1:0] NOTE_REST = 22'd0;
  localparam logic [DIV_W_DEF-1:0] NOTE_C4   = 22'd95420;
  localparam logic [DIV_W_DEF-1:0] NOTE_E4   = 22'd75758;
  localparam logic [DIV_W_DEF-1:0] NOTE_G4   = 22'd63776;
  localparam logic [DIV_W_DEF-1:0] NOTE_C5   = 22'd47801;
endpackage

// File: rtl/sound_scheduler_tone_gen.sv
// tone_gen: turns a half-period divider into a square wave
//   clk, rst      clock, async active-high reset
//   note_div      half-period in clk cycles, 0 = silence
//   buzz          square-wave output
module tone_gen
  import sound_scheduler_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] note_div,
  output logic             buzz
);
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q;
  logic             buzz_q, buzz_d, wrap, same;
  assign wrap = cnt_q == note_div - DIV_W'(1);
  // a new divider restarts the count from 0 but leaves the output level alone
  assign same = note_div == div_q;
  always_comb begin
    cnt_d  = (note_div == '0 || !same || wrap) ? '0 : cnt_q + DIV_W'(1);
    buzz_d = (note_div == '0) ? 1'b0 : (same && wrap) ? ~buzz_q : buzz_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q  <= '0;
      div_q  <= '0;
      buzz_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= note_div;
      buzz_q <= buzz_d;
    end
  assign buzz = buzz_q;
endmodule

// File: rtl/sound_scheduler.sv
// sound_scheduler: priority arbiter between BGM, SFX and game-over music driving one buzzer
//   bgm/sfx/go_note_div  source dividers, 0 = rest
//   sfx_req              rising edge starts or retriggers the sound effect
//   game_over            sticky request: silent gap then game-over music
//   mute                 silences the output without touching sequencing
//   note_div, src, sfx_busy, go_start, buzz  registered outputs
module sound_scheduler
  import sound_scheduler_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int SFX_LEN = 12500000,
  parameter int GAP_LEN = 5000000,
  parameter int CNT_W   = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] bgm_note_div,
  input  logic [DIV_W-1:0] sfx_note_div,
  input  logic [DIV_W-1:0] go_note_div,
  input  logic             sfx_req,
  input  logic             game_over,
  input  logic             mute,
  output logic [DIV_W-1:0] note_div,
  output logic [1:0]       src,
  output logic             sfx_busy,
  output logic             go_start,
  output logic             buzz
);
  src_e             state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [DIV_W-1:0] note_q, note_d, sel;
  logic             req_q, go_q, go_d, rise;
  assign rise = sfx_req & ~req_q;
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    go_d    = 1'b0;
    sel     = bgm_note_div;
    case (state_q)
      SRC_BGM:
        if (game_over) begin
          state_d = SRC_GAP;
          timer_d = CNT_W'(GAP_LEN - 1);
        end else if (rise) begin
          state_d = SRC_SFX;
          timer_d = CNT_W'(SFX_LEN - 1);
        end
      SRC_SFX: begin
        sel = sfx_note_div;
        if (game_over) begin
          state_d = SRC_GAP;
          timer_d = CNT_W'(GAP_LEN - 1);
        end else if (rise) timer_d = CNT_W'(SFX_LEN - 1);
        else if (timer_q == '0) state_d = SRC_BGM;
        else timer_d = timer_q - CNT_W'(1);
      end
      SRC_GAP: begin
        sel = NOTE_REST;
        if (timer_q == '0) begin
          state_d = SRC_OVER;
          go_d    = 1'b1;
        end else timer_d = timer_q - CNT_W'(1);
      end
      default: sel = go_note_div;
    endcase
    note_d = mute ? '0 : sel;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= SRC_BGM;
      timer_q <= '0;
      note_q  <= '0;
      req_q   <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      note_q  <= note_d;
      req_q   <= sfx_req;
      go_q    <= go_d;
    end
  assign src      = state_q;
  assign sfx_busy = state_q == SRC_SFX;
  assign go_start = go_q;
  assign note_div = note_q;
  tone_gen #(.DIV_W(DIV_W)) u_tone (
    .clk     (clk),
    .rst     (rst),
    .note_div(note_q),
    .buzz    (buzz)
  );
endmodule

// File: tb/tb_sound_scheduler.sv
// tb_sound_scheduler: directed and randomized check of sound_scheduler against a duration-based model
module tb_sound_scheduler;
  localparam int DW = 22, SL = 8, GL = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [DW-1:0] bgm, sfx, gov, note_div;
  logic sfx_req, game_over, mute, sfx_busy, go_start, buzz;
  logic [1:0] src;
  int checks = 0, failures = 0;
  bit chk = 0;
  int m_src, m_rem, m_start, e = 0;
  logic [DW-1:0] m_nd, m_prev_n;
  logic m_go, m_buzz, m_req;

  sound_scheduler #(.DIV_W(DW), .SFX_LEN(SL), .GAP_LEN(GL), .CNT_W(24)) dut (
    .clk(clk), .rst(rst), .bgm_note_div(bgm), .sfx_note_div(sfx), .go_note_div(gov),
    .sfx_req(sfx_req), .game_over(game_over), .mute(mute), .note_div(note_div),
    .src(src), .sfx_busy(sfx_busy), .go_start(go_start), .buzz(buzz)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_src = 0; m_rem = 0; m_nd = '0; m_prev_n = '0; m_go = 0; m_buzz = 0; m_req = 0;
  endtask

  // m_rem counts the cycles still to be spent in the current timed source, including this one
  task automatic step();
    logic rise;
    logic [DW-1:0] sel, n;
    e++;
    if (rst) begin
      model_reset();
      return;
    end
    rise = sfx_req & ~m_req;
    m_req = sfx_req;
    sel = (m_src == 0) ? bgm : (m_src == 1) ? sfx : (m_src == 2) ? '0 : gov;
    n = m_nd;
    if (n == 0) begin
      m_buzz = 0; m_prev_n = 0;
    end else if (n != m_prev_n) begin
      m_start = e; m_prev_n = n;
    end else if ((e - m_start) % int'(n) == 0) m_buzz = ~m_buzz;
    m_go = 0;
    case (m_src)
      0: if (game_over) begin m_src = 2; m_rem = GL; end
         else if (rise) begin m_src = 1; m_rem = SL; end
      1: if (game_over) begin m_src = 2; m_rem = GL; end
         else if (rise) m_rem = SL;
         else if (m_rem == 1) m_src = 0;
         else m_rem--;
      2: if (m_rem == 1) begin m_src = 3; m_go = 1; end
         else m_rem--;
      default: ;
    endcase
    m_nd = mute ? '0 : sel;
  endtask

  task automatic tick();
    @(posedge clk);
    step();
    @(negedge clk);
  endtask

  always @(negedge clk)
    if (chk) begin
      check("src", src, m_src);
      check("note_div", note_div, m_nd);
      check("sfx_busy", sfx_busy, m_src == 1);
      check("go_start", go_start, m_go);
      check("buzz", buzz, m_buzz);
    end

  initial begin
    int n, g;
    bgm = 5; sfx = 3; gov = 6; sfx_req = 0; game_over = 0; mute = 0;
    model_reset();
    chk = 1;
    tick(); tick();
    check("rst_src", src, 0);
    check("rst_note_div", note_div, 0);
    check("rst_buzz", buzz, 0);
    check("rst_go_start", go_start, 0);
    rst = 0;
    tick();
    check("first_note_div", note_div, 5);
    n = 0;
    while (buzz == 0 && n < 20) begin tick(); n++; end
    check("first_toggle_seen", buzz, 1);
    n = 0;
    while (buzz == 1 && n < 20) begin tick(); n++; end
    check("half_period", n, 5);
    sfx_req = 1;
    tick();
    check("sfx_enter", src, 1);
    n = 0;
    while (src == 1 && n < 40) begin n++; tick(); end
    check("sfx_len", n, 8);
    tick();
    check("sfx_back_nd", note_div, 5);
    sfx_req = 0;
    tick();
    sfx_req = 1;
    tick();
    sfx_req = 0;
    repeat (4) tick();
    sfx_req = 1;
    n = 5;
    tick();
    while (src == 1 && n < 40) begin n++; tick(); end
    check("retrig_len", n, 13);
    sfx_req = 0; mute = 1;
    tick();
    check("mute_nd", note_div, 0);
    tick();
    check("mute_buzz", buzz, 0);
    check("mute_src", src, 0);
    mute = 0;
    tick();
    check("unmute_nd", note_div, 5);
    tick();
    sfx_req = 1; game_over = 1;
    tick();
    check("gap_enter", src, 2);
    n = 0; g = 0;
    while (src == 2 && n < 20) begin n++; if (go_start) g++; tick(); end
    check("gap_len", n, 4);
    if (go_start) g++;
    check("over_enter", src, 3);
    repeat (3) begin tick(); if (go_start) g++; end
    check("go_pulses", g, 1);
    repeat (4) begin sfx_req = ~sfx_req; tick(); end
    check("over_stays", src, 3);
    check("over_nd", note_div, 6);
    #1 rst = 1;
    model_reset();
    #1;
    check("mid_rst_src", src, 0);
    check("mid_rst_nd", note_div, 0);
    check("mid_rst_buzz", buzz, 0);
    check("mid_rst_go", go_start, 0);
    tick();
    rst = 0; game_over = 0; sfx_req = 0;
    tick();
    repeat (3000) begin
      if ($urandom_range(0, 5) == 0) sfx_req = ~sfx_req;
      if ($urandom_range(0, 149) == 0) game_over = 1;
      if ($urandom_range(0, 29) == 0) mute = ~mute;
      if ($urandom_range(0, 39) == 0) bgm = DW'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) sfx = DW'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) gov = DW'($urandom_range(0, 7));
      if ($urandom_range(0, 249) == 0) begin
        #1 rst = 1;
        model_reset();
        game_over = 0;
        tick();
        rst = 0;
      end
      tick();
    end
    chk = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
